// File: rtl/hls_kernel_adapter_pkg.sv
`default_nettype none
// ============================================================================
// hls_kernel_adapter_pkg : shared state encoding and default widths
// Rev 1.0
// ============================================================================
package hls_kernel_adapter_pkg;

  localparam int unsigned c_DEF_N_IN   = 2;
  localparam int unsigned c_DEF_N_OUT  = 1;
  localparam int unsigned c_DEF_DW     = 32;
  localparam int unsigned c_DEF_ITER_W = 16;
  localparam int unsigned c_DEF_IN_BUF = 1;
  localparam int unsigned c_DEF_CNT_W  = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/hls_stream_kernel_adapter_if.sv
`default_nettype none
// ============================================================================
// hls_stream_kernel_adapter_if : bundle of N valid/ready stream channels
// Rev 1.0
// ============================================================================
interface hls_stream_kernel_adapter_if #(
  parameter int unsigned N  = 1,
  parameter int unsigned DW = 32
);
  logic [N*DW-1:0] data;
  logic [N-1:0]    valid;
  logic [N-1:0]    ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/hls_stream_skid_buffer.sv
`default_nettype none
// ============================================================================
// hls_stream_skid_buffer : 2-entry valid/ready skid with registered ready
// Rev 1.0
// ============================================================================
module hls_stream_skid_buffer #(
  parameter int unsigned DW = 32
) (
  input  wire logic          clk_i,
  input  wire logic          rst_ni,
  input  wire logic          clear_i,
  input  wire logic [DW-1:0] data_i,
  input  wire logic          valid_i,
  output logic               ready_o,
  output logic [DW-1:0]      data_o,
  output logic               valid_o,
  input  wire logic          ready_i
);

  logic [DW-1:0] r_mem [2];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_count;
  logic          w_push;
  logic          w_pop;

  // ready is a flop bit: count saturates at 2, so bit 1 means full
  assign ready_o = ~r_count[1];
  assign valid_o = (r_count != 2'd0);
  assign data_o  = r_mem[r_rd_ptr];
  assign w_push  = valid_i & ready_o;
  assign w_pop   = valid_o & ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (clear_i) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= data_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/hls_stream_kernel_adapter.sv
`default_nettype none
// ============================================================================
// hls_stream_kernel_adapter : multi-iteration ap_ctrl_hs launcher and stream glue
// Rev 1.0
// ============================================================================
module hls_stream_kernel_adapter
  import hls_kernel_adapter_pkg::*;
#(
  parameter int unsigned N_IN   = c_DEF_N_IN,
  parameter int unsigned N_OUT  = c_DEF_N_OUT,
  parameter int unsigned DW     = c_DEF_DW,
  parameter int unsigned ITER_W = c_DEF_ITER_W,
  parameter int unsigned IN_BUF = c_DEF_IN_BUF,
  parameter int unsigned CNT_W  = c_DEF_CNT_W
) (
  input  wire logic                   clk_i,
  input  wire logic                   rst_ni,
  input  wire logic                   test_mode_i,
  input  wire logic                   clear_i,
  input  wire logic                   start_i,
  input  wire logic [ITER_W-1:0]      num_iter_i,
  hls_stream_kernel_adapter_if.slave  in_if,
  hls_stream_kernel_adapter_if.master k_in_if,
  hls_stream_kernel_adapter_if.slave  k_out_if,
  hls_stream_kernel_adapter_if.master out_if,
  output logic [N_OUT*DW/8-1:0]       out_strb_o,
  output logic                        ap_start_o,
  input  wire logic                   ap_ready_i,
  input  wire logic                   ap_done_i,
  input  wire logic                   ap_idle_i,
  output logic                        done_o,
  output logic                        busy_o,
  output logic                        idle_o,
  output logic [N_OUT*CNT_W-1:0]      out_beats_o
);

  state_e            r_state;
  state_e            w_state_next;
  logic [ITER_W-1:0] r_n_iter;
  logic [ITER_W-1:0] r_issued;
  logic [ITER_W-1:0] r_completed;
  logic [ITER_W-1:0] w_issued_next;
  logic [ITER_W-1:0] w_completed_next;
  logic              r_ap_start;
  logic              w_ap_start_next;
  logic              r_zero_done;
  logic              w_launch;
  logic              w_zero_launch;
  logic              w_issue;
  logic              w_complete;
  logic              w_busy;
  logic              w_unused_test_mode;

  assign w_unused_test_mode = test_mode_i;

  assign w_busy        = (r_state != ST_IDLE);
  assign w_launch      = (r_state == ST_IDLE) && start_i && (num_iter_i != '0);
  assign w_zero_launch = (r_state == ST_IDLE) && start_i && (num_iter_i == '0);
  assign w_issue       = (r_state == ST_RUN) && r_ap_start && ap_ready_i;
  // a done beyond the job's iteration count must not be counted
  assign w_complete    = (r_state == ST_RUN) && ap_done_i && (r_completed != r_n_iter);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_n_iter    <= '0;
      r_issued    <= '0;
      r_completed <= '0;
      r_ap_start  <= 1'b0;
      r_zero_done <= 1'b0;
    end else if (clear_i) begin
      r_state     <= ST_IDLE;
      r_n_iter    <= '0;
      r_issued    <= '0;
      r_completed <= '0;
      r_ap_start  <= 1'b0;
      r_zero_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_n_iter    <= w_launch ? num_iter_i : r_n_iter;
      r_issued    <= w_issued_next;
      r_completed <= w_completed_next;
      r_ap_start  <= w_ap_start_next;
      r_zero_done <= w_zero_launch;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_issued_next    = r_issued + ITER_W'(w_issue);
    w_completed_next = r_completed + ITER_W'(w_complete);
    w_ap_start_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          w_state_next     = ST_RUN;
          w_issued_next    = '0;
          w_completed_next = '0;
          w_ap_start_next  = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_completed_next == r_n_iter) begin
          w_state_next = ST_FINISH;
        end else begin
          w_ap_start_next = (w_issued_next < r_n_iter);
        end
      end
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o     = w_busy;
    done_o     = (r_state == ST_FINISH) || r_zero_done;
    idle_o     = (r_state == ST_IDLE) && ap_idle_i;
    ap_start_o = r_ap_start;
  end

  // input channels are gated off in IDLE so early data waits at the streamer
  for (genvar c = 0; c < N_IN; c++) begin : g_in
    if (IN_BUF != 0) begin : g_skid
      logic w_rdy;
      logic w_vld;

      hls_stream_skid_buffer #(
        .DW (DW)
      ) u_skid (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .data_i  (in_if.data[c*DW +: DW]),
        .valid_i (in_if.valid[c] & w_busy),
        .ready_o (w_rdy),
        .data_o  (k_in_if.data[c*DW +: DW]),
        .valid_o (w_vld),
        .ready_i (k_in_if.ready[c] & w_busy)
      );

      assign in_if.ready[c]   = w_rdy & w_busy;
      assign k_in_if.valid[c] = w_vld & w_busy;
    end else begin : g_pass
      assign k_in_if.data[c*DW +: DW] = in_if.data[c*DW +: DW];
      assign k_in_if.valid[c]         = in_if.valid[c] & w_busy;
      assign in_if.ready[c]           = k_in_if.ready[c] & w_busy;
    end
  end

  assign out_if.data    = k_out_if.data;
  assign out_if.valid   = k_out_if.valid;
  assign k_out_if.ready = out_if.ready;
  assign out_strb_o     = '1;

  // counters clear on launch, not on done, so software can read them afterwards
  for (genvar c = 0; c < N_OUT; c++) begin : g_beats
    logic [CNT_W-1:0] r_beats;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_beats <= '0;
      end else if (clear_i || w_launch) begin
        r_beats <= '0;
      end else if (w_busy && k_out_if.valid[c] && out_if.ready[c] && (r_beats != '1)) begin
        r_beats <= r_beats + CNT_W'(1);
      end
    end

    assign out_beats_o[c*CNT_W +: CNT_W] = r_beats;
  end

endmodule
`default_nettype wire

// File: tb/tb_hls_stream_kernel_adapter.sv
`default_nettype none
// ============================================================================
// tb_hls_stream_kernel_adapter : directed stimulus with queue-based scoreboard
// Rev 1.0
// ============================================================================
module tb_hls_stream_kernel_adapter;

  localparam int N_IN   = 2;
  localparam int N_OUT  = 2;
  localparam int DW     = 32;
  localparam int ITER_W = 16;
  localparam int CNT_W  = 3;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     test_mode = 1'b0;
  logic                     clear = 1'b0;
  logic                     start = 1'b0;
  logic [ITER_W-1:0]        num_iter = '0;
  logic                     ap_ready = 1'b0;
  logic                     ap_done = 1'b0;
  logic                     ap_idle = 1'b1;
  logic                     ap_start;
  logic                     done;
  logic                     busy;
  logic                     idle;
  logic [N_OUT*DW/8-1:0]    strb;
  logic [N_OUT*CNT_W-1:0]   beats;

  hls_stream_kernel_adapter_if #(.N(N_IN),  .DW(DW)) in_if ();
  hls_stream_kernel_adapter_if #(.N(N_IN),  .DW(DW)) k_in_if ();
  hls_stream_kernel_adapter_if #(.N(N_OUT), .DW(DW)) k_out_if ();
  hls_stream_kernel_adapter_if #(.N(N_OUT), .DW(DW)) out_if ();

  hls_stream_kernel_adapter #(
    .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .ITER_W(ITER_W), .IN_BUF(1), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .test_mode_i(test_mode), .clear_i(clear),
    .start_i(start), .num_iter_i(num_iter),
    .in_if(in_if), .k_in_if(k_in_if), .k_out_if(k_out_if), .out_if(out_if),
    .out_strb_o(strb), .ap_start_o(ap_start), .ap_ready_i(ap_ready),
    .ap_done_i(ap_done), .ap_idle_i(ap_idle), .done_o(done), .busy_o(busy),
    .idle_o(idle), .out_beats_o(beats)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int occ0    = 0;
  int n_rdy   = 0;

  logic [DW-1:0] exp_k0 [$];
  logic [DW-1:0] exp_out0 [$];
  logic [DW-1:0] exp_out1 [$];
  int            exp_done [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: DUT output with empty scoreboard (cycle %0d)", name, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: compares every DUT presentation against the expected queues
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (exp_done.size() == 0) unexpected("done_pulse");
        else check("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
      end
      if (k_in_if.valid[0] && k_in_if.ready[0]) begin
        if (exp_k0.size() == 0) unexpected("kin0_beat");
        else check("kin0_data", 64'(k_in_if.data[31:0]), 64'(exp_k0.pop_front()));
      end
      if (k_in_if.valid[1] && k_in_if.ready[1]) unexpected("kin1_beat");
      if (occ0 == 2) check("in_ready_when_full", 64'(in_if.ready[0]), 64'd0);
      if (clear) occ0 = 0;
      else occ0 = occ0 + int'(in_if.valid[0] && in_if.ready[0])
                       - int'(k_in_if.valid[0] && k_in_if.ready[0]);
      if (out_if.valid[0] && out_if.ready[0]) begin
        if (exp_out0.size() == 0) unexpected("out0_beat");
        else check("out0_data", 64'(out_if.data[31:0]), 64'(exp_out0.pop_front()));
      end
      if (out_if.valid[1] && out_if.ready[1]) begin
        if (exp_out1.size() == 0) unexpected("out1_beat");
        else check("out1_data", 64'(out_if.data[63:32]), 64'(exp_out1.pop_front()));
      end
      if (ap_start && ap_ready) n_rdy++;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [12:0]   rdy_mask;
  logic [12:0]   done_mask;
  logic [7:0]    v0, r0, v1, r1;
  logic [DW-1:0] beats_in [8];
  logic [DW-1:0] d;
  int            sent;
  int            cycles;
  logic          acc;

  initial begin
    in_if.data = '0;  in_if.valid = '0;
    k_in_if.ready = '0;
    k_out_if.data = '0; k_out_if.valid = '0;
    out_if.ready = '0;
    rdy_mask  = 13'b0_0001_0001_0001;
    done_mask = 13'b1_0101_0000_0000;
    for (int i = 0; i < 8; i++) beats_in[i] = DW'((i + 1) * 8'h11);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ap_start", 64'(ap_start), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_beats", 64'(beats), 64'd0);
    check("rst_idle_hi", 64'(idle), 64'd1);
    ap_idle = 1'b0;
    #1;
    check("rst_idle_follows", 64'(idle), 64'd0);
    ap_idle = 1'b1;
    rst_n = 1'b1;
    tick();

    // input gating in IDLE
    in_if.valid = 2'b11;
    in_if.data  = {32'hBBBB0001, 32'hAAAA0001};
    k_in_if.ready = 2'b11;
    tick();
    check("idle_in_ready", 64'(in_if.ready), 64'd0);
    check("idle_k_in_valid", 64'(k_in_if.valid), 64'd0);
    in_if.valid = 2'b00;
    k_in_if.ready = 2'b00;

    // single invocation
    start = 1'b1; num_iter = 16'd1;
    tick();
    start = 1'b0;
    check("single_ap_start_hi", 64'(ap_start), 64'd1);
    check("single_busy", 64'(busy), 64'd1);
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    check("single_ap_start_drop", 64'(ap_start), 64'd0);
    tick();
    ap_done = 1'b1;
    exp_done.push_back(cyc + 1);
    tick();
    ap_done = 1'b0;
    check("single_finish_busy", 64'(busy), 64'd1);
    start = 1'b1; num_iter = 16'd5;
    tick();
    start = 1'b0;
    check("finish_start_ignored_busy", 64'(busy), 64'd0);
    check("finish_start_ignored_ap", 64'(ap_start), 64'd0);

    // zero iterations
    start = 1'b1; num_iter = 16'd0;
    exp_done.push_back(cyc + 1);
    tick();
    start = 1'b0;
    check("zero_ap_start", 64'(ap_start), 64'd0);
    check("zero_busy", 64'(busy), 64'd0);
    tick();
    check("zero_ap_start_later", 64'(ap_start), 64'd0);
    check("zero_busy_later", 64'(busy), 64'd0);

    // multi-iteration: third ready coincides with first done
    start = 1'b1; num_iter = 16'd3;
    tick();
    start = 1'b0;
    n_rdy = 0;
    for (int i = 0; i <= 12; i++) begin
      ap_ready = rdy_mask[i];
      ap_done  = done_mask[i];
      if (i == 8)  check("multi_ap_start_last", 64'(ap_start), 64'd1);
      if (i == 9)  check("multi_ap_start_low", 64'(ap_start), 64'd0);
      if (i == 11) check("multi_busy_mid", 64'(busy), 64'd1);
      if (i == 12) exp_done.push_back(cyc + 1);
      tick();
    end
    ap_ready = 1'b0; ap_done = 1'b0;
    tick();
    check("multi_ready_count", 64'(n_rdy), 64'd3);
    check("multi_idle_after", 64'(busy), 64'd0);

    // skid backpressure on channel 0
    start = 1'b1; num_iter = 16'd1;
    tick();
    start = 1'b0;
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    sent = 0; cycles = 0;
    while ((sent < 8 || exp_k0.size() != 0) && cycles < 100) begin
      k_in_if.ready[0] = ~cycles[0];
      if (sent < 8) begin
        in_if.valid[0] = 1'b1;
        in_if.data[31:0] = beats_in[sent];
      end else begin
        in_if.valid[0] = 1'b0;
      end
      acc = in_if.valid[0] && in_if.ready[0];
      if (acc) exp_k0.push_back(beats_in[sent]);
      tick();
      if (acc) sent++;
      cycles++;
    end
    in_if.valid = '0; k_in_if.ready = '0;
    check("skid_sent", 64'(sent), 64'd8);
    check("skid_drained", 64'(exp_k0.size()), 64'd0);
    ap_done = 1'b1;
    exp_done.push_back(cyc + 1);
    tick();
    ap_done = 1'b0;
    tick();

    // clear mid-job
    start = 1'b1; num_iter = 16'd4;
    tick();
    start = 1'b0;
    k_out_if.valid = 2'b01; out_if.ready = 2'b01;
    k_out_if.data[31:0] = 32'hC0DE0001; exp_out0.push_back(32'hC0DE0001);
    ap_ready = 1'b1;
    tick();
    k_out_if.data[31:0] = 32'hC0DE0002; exp_out0.push_back(32'hC0DE0002);
    ap_ready = 1'b0; ap_done = 1'b1;
    tick();
    k_out_if.valid = '0; out_if.ready = '0;
    ap_ready = 1'b1; ap_done = 1'b0;
    tick();
    ap_ready = 1'b0; ap_done = 1'b1;
    tick();
    ap_done = 1'b0;
    check("clear_pre_beats", 64'(beats), 64'd2);
    check("clear_pre_ap_start", 64'(ap_start), 64'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_ap_start", 64'(ap_start), 64'd0);
    check("clear_busy", 64'(busy), 64'd0);
    check("clear_beats", 64'(beats), 64'd0);
    start = 1'b1; num_iter = 16'd1;
    tick();
    start = 1'b0;
    check("post_clear_ap_start", 64'(ap_start), 64'd1);
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0; ap_done = 1'b1;
    exp_done.push_back(cyc + 1);
    tick();
    ap_done = 1'b0;
    tick();
    check("post_clear_idle", 64'(busy), 64'd0);

    // output counting with stalls: ch0 5 beats, ch1 3 beats
    start = 1'b1; num_iter = 16'd1;
    tick();
    start = 1'b0;
    ap_ready = 1'b1;
    tick();
    ap_ready = 1'b0;
    v0 = 8'hFF; r0 = 8'b1011_0101;
    v1 = 8'b0111_0110; r1 = 8'b1101_1011;
    for (int i = 0; i < 8; i++) begin
      k_out_if.valid = {v1[i], v0[i]};
      out_if.ready   = {r1[i], r0[i]};
      k_out_if.data  = {32'hB0000000 + 32'(i), 32'hA0000000 + 32'(i)};
      if (v0[i] && r0[i]) exp_out0.push_back(32'hA0000000 + 32'(i));
      if (v1[i] && r1[i]) exp_out1.push_back(32'hB0000000 + 32'(i));
      if (i == 3) check("k_out_ready_pass", 64'(k_out_if.ready), 64'(out_if.ready));
      tick();
    end
    k_out_if.valid = '0; out_if.ready = '0;
    check("out_beats_3_5", 64'(beats), 64'({3'd3, 3'd5}));
    check("out_strb_ones", 64'(strb), 64'hFF);
    ap_done = 1'b1;
    exp_done.push_back(cyc + 1);
    tick();
    ap_done = 1'b0;
    tick();
    check("beats_hold_after_done", 64'(beats), 64'({3'd3, 3'd5}));
    k_out_if.valid = 2'b01; out_if.ready = 2'b01;
    k_out_if.data[31:0] = 32'hD00D0000; exp_out0.push_back(32'hD00D0000);
    tick();
    k_out_if.valid = '0; out_if.ready = '0;
    check("beats_idle_no_count", 64'(beats), 64'({3'd3, 3'd5}));

    // saturation: 9 beats into a 3-bit counter
    start = 1'b1; num_iter = 16'd1;
    tick();
    start = 1'b0;
    check("start_zeroes_beats", 64'(beats), 64'd0);
    ap_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      d = 32'hE0000000 + 32'(i);
      k_out_if.valid = 2'b01; out_if.ready = 2'b01;
      k_out_if.data[31:0] = d;
      exp_out0.push_back(d);
      tick();
      ap_ready = 1'b0;
    end
    k_out_if.valid = '0; out_if.ready = '0;
    check("beats_saturate", 64'(beats), 64'd7);
    ap_done = 1'b1;
    exp_done.push_back(cyc + 1);
    tick();
    ap_done = 1'b0;
    repeat (3) tick();

    check("done_queue_empty", 64'(exp_done.size()), 64'd0);
    check("out0_queue_empty", 64'(exp_out0.size()), 64'd0);
    check("out1_queue_empty", 64'(exp_out1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
